// File: rtl/hello_msg_sequencer.sv
// ---------------------------------------------------------------------------
// hello_msg_sequencer
//
// Sends the fixed 13-byte message "Hello World\r\n" to a UART transmitter
// once per trigger pulse.  Sits between a periodic enable generator (whose
// 1-cycle enable drives i_start) and the UART TX (valid/ready handshake).
// Optionally inserts GAP_CYCLES idle cycles between consecutive characters.
//
// Parameters:
//   GAP_CYCLES   idle cycles (valid low) between characters, 0..255
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   i_start      in   trigger pulse, level-sampled on rising clk
//   i_tx_ready   in   UART TX can accept a byte this cycle
//   o_tx_valid   out  o_tx_data holds a byte for the TX
//   o_tx_data    out  character being offered (8 bits)
//   o_busy       out  frame in progress
//   o_done       out  single-cycle pulse after the last byte is accepted
//   o_overrun    out  sticky: a trigger arrived while a frame was running
// ---------------------------------------------------------------------------
module hello_msg_sequencer #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_tx_ready,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_overrun
);

    // Index of the final character ("\n"); the frame ends on its handshake.
    localparam logic [3:0] LAST_IDX = 4'd12;

    // Value loaded into the gap counter on a handshake.  The GAP state is
    // left when the counter reads zero, so loading GAP_CYCLES-1 yields
    // exactly GAP_CYCLES cycles with valid low.
    localparam logic [7:0] GAP_RELOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [7:0] gap_cnt;

    // Message ROM: "Hello World\r\n".  Out-of-range indices return 0,
    // though idx is never allowed past LAST_IDX.
    function automatic logic [7:0] rom_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h48;  // H
            4'd1:    b = 8'h65;  // e
            4'd2:    b = 8'h6C;  // l
            4'd3:    b = 8'h6C;  // l
            4'd4:    b = 8'h6F;  // o
            4'd5:    b = 8'h20;  // space
            4'd6:    b = 8'h57;  // W
            4'd7:    b = 8'h6F;  // o
            4'd8:    b = 8'h72;  // r
            4'd9:    b = 8'h6C;  // l
            4'd10:   b = 8'h64;  // d
            4'd11:   b = 8'h0D;  // CR
            4'd12:   b = 8'h0A;  // LF
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic handshake;
    assign handshake = o_tx_valid & i_tx_ready;

    // Single sequential block holding the FSM, the character index, the gap
    // counter and every output.  All outputs are registered so the TX sees
    // glitch-free valid/data that change only on a clock edge.  o_tx_data
    // is loaded together with o_tx_valid and is left untouched until the
    // handshake, which keeps the byte stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            gap_cnt    <= 8'd0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_done <= 1'b0;

            // Any trigger outside IDLE is dropped but remembered, including
            // one that coincides with the final handshake of a frame.
            if (i_start && (state != IDLE)) begin
                o_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= SEND;
                        idx        <= 4'd0;
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= rom_byte(4'd0);
                        o_busy     <= 1'b1;
                    end
                end

                SEND: begin
                    if (handshake) begin
                        if (idx == LAST_IDX) begin
                            state      <= IDLE;
                            idx        <= 4'd0;
                            o_tx_valid <= 1'b0;
                            o_tx_data  <= 8'h00;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            // Back-to-back: present the next byte right away.
                            idx       <= idx + 4'd1;
                            o_tx_data <= rom_byte(idx + 4'd1);
                        end else begin
                            idx        <= idx + 4'd1;
                            gap_cnt    <= GAP_RELOAD;
                            o_tx_valid <= 1'b0;
                            state      <= GAP;
                        end
                    end
                end

                GAP: begin
                    // idx already points at the next character here.
                    if (gap_cnt == 8'd0) begin
                        state      <= SEND;
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= rom_byte(idx);
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    idx        <= 4'd0;
                    gap_cnt    <= 8'd0;
                    o_tx_valid <= 1'b0;
                    o_tx_data  <= 8'h00;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hello_msg_sequencer.md
Name: hello_msg_sequencer

Overview:
- Controller that sequences the UART transmitter to send the fixed 13-byte message "Hello World\r\n" once per trigger pulse.
- The trigger is the 1-cycle enable from the periodic enable generator, for example 1 Hz.
- Sits between the enable generator and the UART TX. It holds an internal message ROM, a character index and an FSM, and drives the TX with a valid/ready handshake.
- It also reports busy, done and overrun status.

Parameters:
- GAP_CYCLES, default 0: number of idle clock cycles inserted between consecutive characters, with o_tx_valid low. Legal range 0..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_start  in  1  trigger pulse; sampled on rising clk; connects to the enable generator o_en
- i_tx_ready  in  1  UART TX can accept a byte this cycle
- o_tx_valid  out  1  o_tx_data holds a byte for the TX
- o_tx_data  out  8  character being offered
- o_busy  out  1  frame in progress
- o_done  out  1  single-cycle pulse marking the end of a frame
- o_overrun  out  1  sticky flag: a trigger arrived while busy

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all outputs are 0: o_tx_valid=0, o_tx_data=8'h00, o_busy=0, o_done=0, o_overrun=0.
- On reset assertion, state=IDLE, idx=0 and gap_cnt=0 immediately, with no clock needed.
- ROM contents, idx 0..12: 48 65 6C 6C 6F 20 57 6F 72 6C 64 0D 0A.
- idx is 4 bits and never exceeds 12.
- A handshake occurs on any cycle where o_tx_valid=1 and i_tx_ready=1.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - o_tx_valid=0 and o_busy=0.
  - If i_start=1, go to SEND with idx=0.
  - Latency: o_tx_valid=1 and o_tx_data=8'h48 on the cycle immediately after the cycle where i_start is sampled.
- SEND:
  - o_tx_valid=1, o_tx_data=ROM[idx] (registered), o_busy=1.
  - o_tx_data and o_tx_valid must stay stable until a handshake occurs. Deasserting valid without a handshake is forbidden.
  - On a handshake with idx<12:
    - If GAP_CYCLES=0: idx=idx+1 and stay in SEND. The next byte is presented on the next cycle, so back-to-back transfers are possible every cycle.
    - If GAP_CYCLES>0: idx=idx+1, gap_cnt=GAP_CYCLES-1, go to GAP.
  - On a handshake with idx=12: go to IDLE, idx=0. o_done=1 for exactly the next cycle; in that cycle o_busy=0 and o_tx_valid=0.
- GAP:
  - o_tx_valid=0, o_busy=1.
  - gap_cnt decrements each cycle. When gap_cnt=0, go to SEND.
  - Exactly GAP_CYCLES cycles with valid low separate consecutive handshakes.
- Overrun:
  - i_start=1 in any state other than IDLE is ignored and sets o_overrun=1.
  - This includes the SEND cycle carrying the final handshake.
  - o_overrun stays set until reset; nothing else clears it.
  - A frame is never restarted or truncated by a trigger.
- Triggers are level-sampled: i_start held high in IDLE starts one frame. While it stays high during the frame, each cycle counts as an overrun (the flag is sticky).
- i_tx_ready while o_tx_valid=0 is ignored.
- i_tx_ready may be held high permanently. A full frame then takes 13 cycles from the first valid cycle when GAP_CYCLES=0, and 13+12*GAP_CYCLES cycles otherwise.
- Reset mid-frame: valid drops immediately; the frame is abandoned with no resume. The next trigger restarts at 'H'.
- o_done is never asserted for an aborted frame.

Test Plan:
- Reset, then i_start pulse for 1 cycle with i_tx_ready=1 and GAP_CYCLES=0 -> valid rises the next cycle. The bytes 48 65 6C 6C 6F 20 57 6F 72 6C 64 0D 0A transfer on 13 consecutive cycles. o_done pulses once on the 14th cycle. o_busy is high for exactly 13 cycles. o_overrun=0.
- Backpressure: i_tx_ready low for 5 cycles at each byte -> o_tx_data is stable at each byte while stalled. The sequence is correct, with no skipped or duplicated bytes, and o_done pulses once.
- GAP_CYCLES=3 with i_tx_ready=1 -> exactly 3 valid-low cycles between handshakes, and a total frame of 13+36=49 cycles from first valid to last handshake.
- i_start pulsed at the 5th byte, and again on the final-handshake cycle -> the frame completes unaltered and o_overrun=1. After reset, o_overrun=0.
- Reset asserted asynchronously, between clock edges, during byte 7 -> all outputs read 0 before the next clk edge. After release, an i_start pulse produces 8'h48 as the first byte and a complete 13-byte frame.
- Two i_start pulses 20 cycles apart with i_tx_ready=1 -> two complete frames, two o_done pulses, and o_overrun=0.
